fp_add_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; next generation of the FP32 combinational adder.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_norm_round.sv | 63 ++++++
 rtl/fp_add_pipe.sv | 93 +++++++++
 tb/tb_fp_add_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, field helpers, special-value classes and flag positions for the FP adder
package fp_pkg;
   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;
   localparam int FLAG_INVALID = 3;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT = 0;
   typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;
   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction
   function automatic logic [63:0] bits_of(input logic [63:0] w, input int lsb, input int n);
      return (w >> lsb) & ((64'd1 << n) - 64'd1);
   endfunction
   // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set
   function automatic logic [63:0] qnan(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
   endfunction
endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise, round-to-nearest-even and pack one raw sum, resolving special tags
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                 sign,
   input  logic                 zsign,
   input  logic [EXP_W+1:0]     exp,
   input  logic [MAN_W+4:0]     sig,
   input  fp_class_e            tag,
   input  logic                 invalid,
   output logic [EXP_W+MAN_W:0] res,
   output logic [3:0]           flags
);
   localparam int LZW = $clog2(MAN_W + 4);
   localparam logic [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
   logic [LZW-1:0] lz;
   logic [MAN_W+3:0] n;
   logic [EXP_W+1:0] e, er;
   logic [MAN_W+1:0] r;
   logic [MAN_W-1:0] frac;
   logic inx, up, ovf, unf;
   always_comb begin
      lz = '0;
      for (int i = 0; i < MAN_W + 4; i++) if (sig[i]) lz = LZW'(MAN_W + 3 - i);
      n = sig[MAN_W+4] ? {sig[MAN_W+4:2], sig[1] | sig[0]} : sig[MAN_W+3:0] << lz;
      e = sig[MAN_W+4] ? exp + 1'b1 : exp - (EXP_W+2)'(lz);
      inx = |n[2:0];
      up = n[2] & (n[1] | n[0] | n[3]);
      r = {1'b0, n[MAN_W+3:3]} + (MAN_W+2)'(up);
      er = e + (EXP_W+2)'(r[MAN_W+1]);
      frac = r[MAN_W+1] ? r[MAN_W:1] : r[MAN_W-1:0];
      ovf = !er[EXP_W+1] && er >= EMAX;
      unf = er[EXP_W+1] || er == '0;
      res = {sign, er[EXP_W-1:0], frac};
      flags = '0;
      flags[FLAG_INEXACT] = inx;
      if (ovf) begin
         res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags[FLAG_OVERFLOW] = 1'b1;
         flags[FLAG_INEXACT] = 1'b1;
      end else if (unf) begin
         res = {sign, {(EXP_W+MAN_W){1'b0}}};
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT] = 1'b1;
      end
      if (sig == '0) begin
         res = {zsign, {(EXP_W+MAN_W){1'b0}}};
         flags = '0;
      end
      if (tag == INF) begin
         res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags = '0;
      end
      if (tag == QNAN) begin
         res = (EXP_W+MAN_W+1)'(qnan(EXP_W, MAN_W));
         flags = '0;
         flags[FLAG_INVALID] = invalid;
      end
   end
endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor (align, add, normalise/round)
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] sum,
   output logic [3:0]           flags
);
   localparam int SW = MAN_W + 4;
   logic sa, sb, sw, sgn, inv;
   logic s1_valid, s1_sign, s1_zsign, s1_eff, s1_inv, s2_valid, s2_sign, s2_zsign, s2_inv;
   logic [EXP_W-1:0] ea, eb, el, es, d;
   logic [MAN_W-1:0] fa, fb;
   logic [SW-1:0] ga, gb, gl, gs, sig_s, s1_l, s1_s;
   logic [EXP_W+1:0] s1_exp, s2_exp;
   logic [SW:0] s2_sig;
   logic [EXP_W+MAN_W:0] res;
   logic [3:0] res_flags;
   fp_class_e ca, cb, tag, s1_tag, s2_tag;
   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      return e == '0 ? ZERO : e != '1 ? NORM : f == '0 ? INF : f[MAN_W-1] ? QNAN : SNAN;
   endfunction
   assign in_ready = !out_valid || out_ready;
   always_comb begin
      sa = a[EXP_W+MAN_W];
      sb = b[EXP_W+MAN_W] ^ sub;
      ea = EXP_W'(bits_of(64'(a), MAN_W, EXP_W));
      eb = EXP_W'(bits_of(64'(b), MAN_W, EXP_W));
      fa = ea == '0 ? '0 : MAN_W'(bits_of(64'(a), 0, MAN_W));
      fb = eb == '0 ? '0 : MAN_W'(bits_of(64'(b), 0, MAN_W));
      ca = classify(ea, fa);
      cb = classify(eb, fb);
      ga = {ea != '0, fa, 3'b000};
      gb = {eb != '0, fb, 3'b000};
      sw = {eb, fb} > {ea, fa};
      el = sw ? eb : ea;
      es = sw ? ea : eb;
      gl = sw ? gb : ga;
      gs = sw ? ga : gb;
      d = el - es;
      // Bits shifted past the sticky position collapse into it; huge d leaves only sticky
      sig_s = (gs >> d) | SW'(|(gs & ((SW'(1) << d) - SW'(1))));
      inv = ca == SNAN || cb == SNAN || (ca == INF && cb == INF && sa != sb);
      tag = inv || ca == QNAN || cb == QNAN ? QNAN : ca == INF || cb == INF ? INF : NORM;
      sgn = tag == INF ? (ca == INF ? sa : sb) : (sw ? sb : sa);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         out_valid <= 1'b0;
         sum <= '0;
         flags <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         s1_tag <= tag;
         s1_inv <= inv;
         s1_sign <= sgn;
         s1_zsign <= sa & sb;
         s1_eff <= sa ^ sb;
         s1_exp <= (EXP_W+2)'(el);
         s1_l <= gl;
         s1_s <= sig_s;
         s2_valid <= s1_valid;
         s2_tag <= s1_tag;
         s2_inv <= s1_inv;
         s2_sign <= s1_sign;
         s2_zsign <= s1_zsign;
         s2_exp <= s1_exp;
         s2_sig <= s1_eff ? {1'b0, s1_l} - {1'b0, s1_s} : {1'b0, s1_l} + {1'b0, s1_s};
         out_valid <= s2_valid;
         if (s2_valid) begin
            sum <= res;
            flags <= res_flags;
         end
      end
   end
   fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
      .sign(s2_sign), .zsign(s2_zsign), .exp(s2_exp), .sig(s2_sig), .tag(s2_tag),
      .invalid(s2_inv), .res(res), .flags(res_flags)
   );
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: random and directed checks of the FP32 and FP16 adder against an exact-arithmetic model
module tb_fp_add_pipe;
   logic clk = 0, rst = 1, in_valid = 0, sub = 0, out_ready = 1, in_ready, out_valid;
   logic [31:0] a = 0, b = 0, sum;
   logic [3:0] flags;
   logic h_in_valid = 0, h_sub = 0, h_out_ready = 1, h_in_ready, h_out_valid;
   logic [15:0] h_a = 0, h_b = 0, h_sum;
   logic [3:0] h_flags;
   logic [35:0] q[$];
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   fp_add_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .flags(flags)
   );
   fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b), .sub(h_sub),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .sum(h_sum), .flags(h_flags)
   );

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   // Exact sum as a wide integer in units of the smallest normal ulp, then RNE to the target format
   function automatic logic [35:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic s,
                                           input int ew, input int mw);
      int emax, ex, ey, p, sh, e;
      logic [31:0] mmask, fx, fy, qn;
      logic [319:0] mx, my, mag, qv, rem, half;
      logic sx, sy, nx, ny, ix, iy, rs;
      logic [3:0] fl;
      emax = (1 << ew) - 1;
      mmask = (32'd1 << mw) - 32'd1;
      qn = (32'(emax) << mw) | (32'd1 << (mw - 1));
      sx = x[ew+mw];
      sy = y[ew+mw] ^ s;
      ex = int'((x >> mw) & 32'(emax));
      ey = int'((y >> mw) & 32'(emax));
      fx = x & mmask;
      fy = y & mmask;
      nx = ex == emax && fx != 0;
      ny = ey == emax && fy != 0;
      ix = ex == emax && fx == 0;
      iy = ey == emax && fy == 0;
      if (nx || ny) return {(nx && !fx[mw-1]) || (ny && !fy[mw-1]), 3'b000, qn};
      if (ix && iy && sx != sy) return {4'b1000, qn};
      if (ix) return {4'b0000, (32'(sx) << (ew + mw)) | (32'(emax) << mw)};
      if (iy) return {4'b0000, (32'(sy) << (ew + mw)) | (32'(emax) << mw)};
      mx = ex == 0 ? '0 : (320'(fx) | (320'd1 << mw)) << (ex - 1);
      my = ey == 0 ? '0 : (320'(fy) | (320'd1 << mw)) << (ey - 1);
      if (sx == sy) begin mag = mx + my; rs = sx; end
      else if (mx >= my) begin mag = mx - my; rs = sx; end
      else begin mag = my - mx; rs = sy; end
      if (mag == 0) return {4'b0000, 32'(sx & sy) << (ew + mw)};
      p = 0;
      for (int i = 0; i < 320; i++) if (mag[i]) p = i;
      sh = p - mw;
      e = p + 1 - mw;
      fl = 4'b0000;
      if (sh > 0) begin
         qv = mag >> sh;
         rem = mag & ((320'd1 << sh) - 320'd1);
         half = 320'd1 << (sh - 1);
         fl[0] = rem != 0;
         if (rem > half || (rem == half && qv[0])) qv = qv + 320'd1;
         if ((qv >> (mw + 1)) != 0) begin qv = qv >> 1; e++; end
      end else qv = mag << (-sh);
      if (e >= emax) return {4'b0101, (32'(rs) << (ew + mw)) | (32'(emax) << mw)};
      if (e <= 0) return {4'b0011, 32'(rs) << (ew + mw)};
      return {fl, (32'(rs) << (ew + mw)) | (32'(e) << mw) | (32'(qv) & mmask)};
   endfunction

   function automatic logic [31:0] rnd_op(input logic [31:0] r);
      logic [31:0] sp [8] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00000, 32'h7F800001, 32'h7F7FFFFF, 32'h00400000};
      int e;
      case ($urandom_range(0, 9))
         0: return $urandom;
         1: return sp[$urandom_range(0, 7)];
         2: return r ^ 32'h80000000;
         default: begin
            e = int'(r[30:23]) + int'($urandom_range(0, 8)) - 4;
            e = e < 1 ? 1 : e > 254 ? 254 : e;
            return {1'($urandom), 8'(e), 23'($urandom)};
         end
      endcase
   endfunction

   task automatic lat_op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [35:0] want);
      int n = 0;
      @(negedge clk);
      in_valid = 1; a = x; b = y; sub = s; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      while (!out_valid && n < 10) begin @(negedge clk); n++; end
      check("latency", 36'(n), 36'd2);
      check("directed", {flags, sum}, want);
   endtask

   task automatic h_op(input logic [15:0] x, input logic [15:0] y, input logic s, input logic [35:0] want);
      int n = 0;
      @(negedge clk);
      h_in_valid = 1; h_a = x; h_b = y; h_sub = s;
      @(negedge clk);
      h_in_valid = 0;
      while (!h_out_valid && n < 10) begin @(negedge clk); n++; end
      check("h_latency", 36'(n), 36'd2);
      check("h_result", {h_flags, 16'h0000, h_sum}, want);
   endtask

   task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic r, output logic acc);
      @(negedge clk);
      in_valid = v; a = x; b = y; sub = s; out_ready = r;
      #1;
      if (out_valid) begin
         if (q.size() == 0) check("spurious", 36'(out_valid), 36'd0);
         else begin
            check("sum", 36'(sum), 36'(q[0][31:0]));
            check("flags", 36'(flags), 36'(q[0][35:32]));
            if (r) void'(q.pop_front());
         end
      end
      acc = v && in_ready;
      if (acc) q.push_back(ref_add(x, y, s, 8, 23));
   endtask

   task automatic stream(input int n, input int pv, input int pr, input int lo, input int hi);
      int sent = 0, cyc = 0;
      logic v = 0, s = 0, r, acc;
      logic [31:0] x = 0, y = 0;
      while ((sent < n || q.size() != 0) && cyc < 5000) begin
         if (!v && sent < n && int'($urandom_range(0, 99)) < pv) begin
            x = rnd_op($urandom);
            y = rnd_op(x);
            s = 1'($urandom);
            v = 1;
         end
         r = !(cyc >= lo && cyc < hi) && int'($urandom_range(0, 99)) < pr;
         cycle(v, x, y, s, r, acc);
         if (acc) begin v = 0; sent++; end
         cyc++;
      end
      check("drained", 36'(q.size()), 36'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      logic [15:0] hx, hy;
      logic hs;
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      check("rst_valid", 36'(out_valid), 36'd0);
      check("rst_sum", 36'(sum), 36'd0);
      check("rst_flags", 36'(flags), 36'd0);
      check("rst_ready", 36'(in_ready), 36'd1);
      check("h_rst_valid", 36'(h_out_valid), 36'd0);
      lat_op(32'h3F800000, 32'h3F800000, 0, {4'h0, 32'h40000000});
      lat_op(32'h3F800000, 32'h33800000, 0, {4'h1, 32'h3F800000});
      lat_op(32'h3F800001, 32'h33800000, 0, {4'h1, 32'h3F800002});
      lat_op(32'h40400000, 32'h40400000, 1, {4'h0, 32'h00000000});
      lat_op(32'h80000000, 32'h80000000, 0, {4'h0, 32'h80000000});
      lat_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0, {4'h5, 32'h7F800000});
      lat_op(32'h7F800000, 32'hFF800000, 0, {4'h8, 32'h7FC00000});
      lat_op(32'h7F800001, 32'h3F800000, 0, {4'h8, 32'h7FC00000});
      lat_op(32'h7FC00001, 32'h3F800000, 0, {4'h0, 32'h7FC00000});
      lat_op(32'hFF800000, 32'h3F800000, 0, {4'h0, 32'hFF800000});
      lat_op(32'h00800001, 32'h00800000, 1, {4'h3, 32'h00000000});
      stream(8, 100, 100, 3, 7);
      stream(400, 70, 70, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, $urandom, $urandom, 0, 0, acc);
      @(negedge clk);
      rst = 1;
      in_valid = 0;
      @(negedge clk);
      check("mid_rst_valid", 36'(out_valid), 36'd0);
      rst = 0;
      q.delete();
      repeat (8) cycle(0, 0, 0, 0, 1, acc);
      check("mid_rst_quiet", 36'(out_valid), 36'd0);
      h_op(16'h3C00, 16'h3C00, 0, {4'h0, 32'h00004000});
      for (int i = 0; i < 20; i++) begin
         hx = 16'($urandom);
         hy = 16'($urandom);
         hs = 1'($urandom);
         h_op(hx, hy, hs, ref_add({16'h0, hx}, {16'h0, hy}, hs, 5, 10));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
